mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4:1 multiplexed datapath among four requesters.
- Drives the 2-bit select of the generic 4:1 mux directly. Grants whole bursts and holds the grant until the owner's last beat transfers.
- Sits between four producer ports and a single downstream consumer with a valid/ready handshake.

---
 rtl/mux4_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin burst arbiter driving the select of a shared 4:1 datapath mux.
// Optional burst-length timeout is compiled in with `define ARB_TIMEOUT_EN.
module mux4_rr_arbiter #(
  parameter int unsigned RESET_PTR = 0,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] req_last,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  localparam logic [1:0] ResetPtr = RESET_PTR[1:0];

  if (RESET_PTR > 3 || MAX_BEATS < 1) begin : gen_bad_param
    $error("mux4_rr_arbiter: RESET_PTR must be 0..3 and MAX_BEATS >= 1");
  end

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] next_ptr;
  logic       locked;
  logic       xfer;
  logic       owner_last;
  logic       forced;
  logic       burst_end;
  logic       load;

  // First asserted request at or after p, wrapping 3 -> 0.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] win;
    win = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) win = idx;
    end
    return win;
  endfunction

  assign locked     = (state_q == StLocked);
  assign xfer       = locked && req[owner_q] && out_ready;
  assign owner_last = req_last[owner_q];
  assign burst_end  = xfer && (owner_last || forced);
  assign next_ptr   = owner_q + 2'd1;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StLocked;
          owner_d = rr_pick(req, ptr_q);
          load    = 1'b1;
        end
      end
      StLocked: begin
        if (burst_end) begin
          ptr_d = next_ptr;
          // Zero-bubble handoff; the old owner now ranks last.
          if (|req) begin
            owner_d = rr_pick(req, next_ptr);
            load    = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= 2'd0;
      ptr_q   <= ResetPtr;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(MAX_BEATS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MAX_BEATS - 1);

  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
  logic            timeout_q;

  // The transfer that would make the count reach MAX_BEATS ends the burst.
  assign forced = xfer && !owner_last && (beat_cnt_q == LastCnt);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (load || burst_end) begin
      beat_cnt_d = '0;
    end else if (xfer) begin
      beat_cnt_d = beat_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      timeout_q  <= forced;
    end
  end

  assign timeout = timeout_q;
`else
  assign forced  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    out_valid = 1'b0;
    sel       = 2'd0;
    gnt       = 4'b0000;
    busy      = 1'b0;
    if (locked) begin
      out_valid = req[owner_q];
      sel       = owner_q;
      gnt       = 4'b0001 << owner_q;
      busy      = 1'b1;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Table-driven bench for mux4_rr_arbiter with a transfer scoreboard.
// Define ARB_TIMEOUT_EN for both RTL and bench to exercise the timeout vectors.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] req_last;
  logic       out_ready;
  logic       out_valid;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       busy;
  logic       timeout;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(
    .RESET_PTR(0),
    .MAX_BEATS(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_last (req_last),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .sel      (sel),
    .gnt      (gnt),
    .busy     (busy),
    .timeout  (timeout)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       ov;
    logic       to;
  } vec_t;

  vec_t       tbl[$];
  logic [1:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

  function automatic vec_t mk(input logic rst, input logic [3:0] r, input logic [3:0] l,
                              input logic rdy, input logic [3:0] g, input logic [1:0] s,
                              input logic b, input logic ov, input logic to);
    vec_t v;
    v.rst = rst; v.req = r; v.last = l; v.rdy = rdy;
    v.gnt = g; v.sel = s; v.busy = b; v.ov = ov; v.to = to;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, compare 1ns later, score any transfer at the rising edge.
  task automatic apply(input vec_t v, input int idx);
    logic       xfer_seen;
    logic [1:0] sel_seen;
    @(negedge clk);
    rst_n     = v.rst;
    req       = v.req;
    req_last  = v.last;
    out_ready = v.rdy;
    if (v.ov && v.rdy) exp_q.push_back(v.sel);
    #1;
    check($sformatf("v%0d gnt", idx), 32'(gnt), 32'(v.gnt));
    check($sformatf("v%0d sel", idx), 32'(sel), 32'(v.sel));
    check($sformatf("v%0d busy", idx), 32'(busy), 32'(v.busy));
    check($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(v.ov));
    check($sformatf("v%0d timeout", idx), 32'(timeout), 32'(v.to));
    xfer_seen = rst_n && out_valid && out_ready;
    sel_seen  = sel;
    @(posedge clk);
    if (xfer_seen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL v%0d unexpected transfer: got sel %0d expected none", idx, sel_seen);
      end else begin
        check($sformatf("v%0d xfer sel", idx), 32'(sel_seen), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic run_table(input int base);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], base + i);
    tbl.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req       = 4'b1111;
    req_last  = 4'b1111;
    out_ready = 1'b1;

    // Reset release with all requesting; single-beat bursts rotate 0,1,2,3,0.
    tbl.push_back(mk(0, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 1, 4'h1, 0, 1, 1, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 1, 4'h2, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 1, 4'h4, 2, 1, 1, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 1, 4'h8, 3, 1, 1, 0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 1, 4'h1, 0, 1, 1, 0));
    // Hand to owner 2, then a 3-beat burst with ready 1,0,1,1; sel held at 2.
    tbl.push_back(mk(1, 4'h6, 4'h2, 1, 4'h2, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'h4, 4'h0, 1, 4'h4, 2, 1, 1, 0));
    tbl.push_back(mk(1, 4'h4, 4'h0, 0, 4'h4, 2, 1, 1, 0));
    tbl.push_back(mk(1, 4'h4, 4'h0, 1, 4'h4, 2, 1, 1, 0));
    tbl.push_back(mk(1, 4'h4, 4'h4, 1, 4'h4, 2, 1, 1, 0));
    // Owner 2 (re-granted, sole requester on its last beat) idles its req for 5 cycles.
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 4'h1, 4'h0, 1, 4'h4, 2, 1, 0, 0));
    tbl.push_back(mk(1, 4'h5, 4'h4, 1, 4'h4, 2, 1, 1, 0));
    // Zero-bubble handoffs: 0 -> 1 -> 3 -> 0 -> 1 under req=1011.
    tbl.push_back(mk(1, 4'h3, 4'h1, 1, 4'h1, 0, 1, 1, 0));
    tbl.push_back(mk(1, 4'hB, 4'h2, 1, 4'h2, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'hB, 4'h8, 1, 4'h8, 3, 1, 1, 0));
    tbl.push_back(mk(1, 4'hB, 4'h1, 1, 4'h1, 0, 1, 1, 0));
    // Stall, last without ready, and non-owner lasts must not move the grant.
    tbl.push_back(mk(1, 4'hB, 4'h0, 0, 4'h2, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'hB, 4'h2, 0, 4'h2, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'hB, 4'hD, 1, 4'h2, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'hB, 4'h0, 1, 4'h2, 1, 1, 1, 0));
    // Owner 1 ends with req=1010 -> owner 3, which starts a burst.
    tbl.push_back(mk(1, 4'hA, 4'h2, 1, 4'h2, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'h8, 4'h0, 1, 4'h8, 3, 1, 1, 0));
    run_table(0);

    // Asynchronous reset mid-burst with owner 3.
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst gnt", 32'(gnt), 32'h0);
    check("async rst busy", 32'(busy), 32'h0);
    check("async rst sel", 32'(sel), 32'h0);
    check("async rst out_valid", 32'(out_valid), 32'h0);

    // ptr back at 0: req=1010 picks 1 (a stale ptr of 2 would pick 3).
    tbl.push_back(mk(0, 4'hA, 4'h0, 1, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'hA, 4'h0, 1, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'hA, 4'h0, 0, 4'h2, 1, 1, 1, 0));
`ifdef ARB_TIMEOUT_EN
    // Owner 0 streams without last; forced release after beat 4 hands to owner 1.
    tbl.push_back(mk(1, 4'h3, 4'h2, 1, 4'h2, 1, 1, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 4'h3, 4'h0, 1, 4'h1, 0, 1, 1, 0));
    tbl.push_back(mk(1, 4'h3, 4'h0, 0, 4'h2, 1, 1, 1, 1));
    tbl.push_back(mk(1, 4'h3, 4'h0, 0, 4'h2, 1, 1, 1, 0));
`endif
    run_table(100);

    check("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
